// File: rtl/riscv_core_mdu_pkg.sv
// rtl/riscv_core_mdu_pkg.sv - shared types and helpers for the M-extension multiply/divide unit
package riscv_core_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} mdu_state_e;

  function automatic logic is_div(input mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(input mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input mdu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/riscv_core_mdu_div_iter.sv
// rtl/riscv_core_mdu_div_iter.sv - combinational non-restoring divide step, DIV_BITS quotient bits
module riscv_core_mdu_div_iter #(
  parameter int XLEN     = 64,
  parameter int DIV_BITS = 1
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] qd,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] qd_next
);

  logic [XLEN:0]   r;
  logic [XLEN:0]   sh;
  logic [XLEN-1:0] q;

  // qd holds the unconsumed dividend bits at the top and the quotient bits
  // shifted in at the bottom; the partial remainder wraps modulo 2^(XLEN+1).
  always_comb begin
    r  = rem;
    q  = qd;
    sh = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      sh = {r[XLEN-1:0], q[XLEN-1]};
      r  = r[XLEN] ? sh + {1'b0, divisor} : sh - {1'b0, divisor};
      q  = {q[XLEN-2:0], ~r[XLEN]};
    end
    rem_next = r;
    qd_next  = q;
  end

endmodule

// File: rtl/riscv_core_mdu.sv
// rtl/riscv_core_mdu.sv - iterative RV64M/RV32M multiply/divide unit with valid/ready handshakes
// Optional divide/remainder pairing cache: RISCV_CORE_MDU_REM_CACHE_EN.
module riscv_core_mdu
  import riscv_core_mdu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int MUL_BITS = 2,
  parameter int DIV_BITS = 1,
  parameter int TAG_W    = 5
) (
  input  logic             i_mdu_clk,
  input  logic             i_mdu_rst,
  input  logic             i_mdu_flush,
  input  logic             i_mdu_in_valid,
  output logic             o_mdu_in_ready,
  input  logic [2:0]       i_mdu_funct3,
  input  logic             i_mdu_isword,
  input  logic [XLEN-1:0]  i_mdu_srcA,
  input  logic [XLEN-1:0]  i_mdu_srcB,
  input  logic [TAG_W-1:0] i_mdu_tag,
  output logic             o_mdu_out_valid,
  input  logic             i_mdu_out_ready,
  output logic [XLEN-1:0]  o_mdu_result,
  output logic [TAG_W-1:0] o_mdu_tag,
  output logic             o_mdu_div_by_zero,
  output logic             o_mdu_overflow
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] MUL_LAST_W = CW'((32 + MUL_BITS - 1) / MUL_BITS - 1);
  localparam logic [CW-1:0] MUL_LAST_X = CW'((XLEN + MUL_BITS - 1) / MUL_BITS - 1);
  localparam logic [CW-1:0] DIV_LAST_W = CW'(32 / DIV_BITS - 1);
  localparam logic [CW-1:0] DIV_LAST_X = CW'(XLEN / DIV_BITS - 1);

  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    logic [63:0] t;
    t = sext32(v);
    return t[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] zx(input logic [31:0] v);
    logic [XLEN-1:0] t;
    t = '0;
    t[31:0] = v;
    return t;
  endfunction

  mdu_state_e        state;
  mdu_op_e           op_q, op_in;
  logic              w32_q, neg_q, neg_r;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] mcand, acc, mul_pp, mul_p;
  logic [XLEN-1:0]   mplier, qd, qd_nx, dvsr, r_fix, q_s, r_s;
  logic [XLEN-1:0]   fix_q, fix_r, mul_res, fix_res;
  logic [XLEN:0]     rem, rem_nx;

  logic              w32_in, div_in, rem_in, sa, sb, ovf_in;
  logic [XLEN-1:0]   a_x, b_x, a_m, b_m, a_res, min_w;
  logic              fast_hit, fast_dbz, fast_ovf;
  logic [XLEN-1:0]   fast_res;
  logic              cache_hit;
  logic [XLEN-1:0]   cache_val;

  assign op_in          = mdu_op_e'(i_mdu_funct3);
  assign o_mdu_in_ready = (state == ST_IDLE);

  // Request decode: effective width, magnitudes and trivial-operand shortcuts.
  always_comb begin
    w32_in = i_mdu_isword || (XLEN == 32);
    div_in = is_div(op_in);
    rem_in = op_in inside {OP_REM, OP_REMU};
    sa     = is_signed_a(op_in) && (w32_in ? i_mdu_srcA[31] : i_mdu_srcA[XLEN-1]);
    sb     = is_signed_b(op_in) && (w32_in ? i_mdu_srcB[31] : i_mdu_srcB[XLEN-1]);
    a_x    = w32_in ? (sa ? sx(i_mdu_srcA[31:0]) : zx(i_mdu_srcA[31:0])) : i_mdu_srcA;
    b_x    = w32_in ? (sb ? sx(i_mdu_srcB[31:0]) : zx(i_mdu_srcB[31:0])) : i_mdu_srcB;
    a_m    = sa ? -a_x : a_x;
    b_m    = sb ? -b_x : b_x;
    a_res  = w32_in ? sx(i_mdu_srcA[31:0]) : i_mdu_srcA;
    min_w  = w32_in ? sx(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    ovf_in = div_in && is_signed_b(op_in) && (b_x == '1) && (a_x == min_w);

    fast_hit = 1'b1;
    fast_dbz = 1'b0;
    fast_ovf = 1'b0;
    fast_res = '0;
    if (cache_hit) begin
      fast_res = cache_val;
    end else if (div_in && (b_x == '0)) begin
      fast_dbz = 1'b1;
      fast_res = rem_in ? a_res : '1;
    end else if (ovf_in) begin
      fast_ovf = 1'b1;
      fast_res = rem_in ? '0 : a_res;
    end else if (!div_in && ((a_x == '0) || (b_x == '0))) begin
      fast_res = '0;
    end else begin
      fast_hit = 1'b0;
    end
  end

  riscv_core_mdu_div_iter #(.XLEN(XLEN), .DIV_BITS(DIV_BITS)) u_div_iter (
    .rem      (rem),
    .qd       (qd),
    .divisor  (dvsr),
    .rem_next (rem_nx),
    .qd_next  (qd_nx)
  );

  always_comb begin
    mul_pp = '0;
    for (int j = 0; j < MUL_BITS; j++)
      if (mplier[j]) mul_pp = mul_pp + (mcand << j);
    mul_p = neg_q ? -acc : acc;
    r_fix = rem[XLEN] ? rem[XLEN-1:0] + dvsr : rem[XLEN-1:0];
    q_s   = neg_q ? -qd : qd;
    r_s   = neg_r ? -r_fix : r_fix;
    fix_q = w32_q ? sx(q_s[31:0]) : q_s;
    fix_r = w32_q ? sx(r_s[31:0]) : r_s;
    if (op_q == OP_MUL) mul_res = w32_q ? sx(mul_p[31:0]) : mul_p[XLEN-1:0];
    else                mul_res = w32_q ? sx(mul_p[63:32]) : mul_p[2*XLEN-1:XLEN];
    if (!is_div(op_q))                      fix_res = mul_res;
    else if (op_q inside {OP_REM, OP_REMU}) fix_res = fix_r;
    else                                    fix_res = fix_q;
  end

`ifdef RISCV_CORE_MDU_REM_CACHE_EN
  logic            c_v, c_w32, c_signed, c_rem;
  logic [XLEN-1:0] c_a, c_b, c_q, c_r;

  assign cache_hit = c_v && div_in && (rem_in != c_rem) && (c_signed == is_signed_b(op_in)) &&
                     (c_w32 == w32_in) && (c_a == i_mdu_srcA) && (c_b == i_mdu_srcB);
  assign cache_val = rem_in ? c_r : c_q;

  // Entry is rebuilt on every iterating divide and becomes valid when it finishes.
  always_ff @(posedge i_mdu_clk) begin
    if (i_mdu_rst || i_mdu_flush) begin
      c_v <= 1'b0;
    end else if (state == ST_IDLE && i_mdu_in_valid && fast_hit && !div_in) begin
      c_v <= 1'b0;
    end else if (state == ST_IDLE && i_mdu_in_valid && !fast_hit && div_in) begin
      c_v      <= 1'b0;
      c_a      <= i_mdu_srcA;
      c_b      <= i_mdu_srcB;
      c_w32    <= w32_in;
      c_signed <= is_signed_b(op_in);
      c_rem    <= rem_in;
    end else if (state == ST_FIX) begin
      c_v <= is_div(op_q);
      c_q <= fix_q;
      c_r <= fix_r;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_val = '0;
`endif

  always_ff @(posedge i_mdu_clk) begin
    if (i_mdu_rst || i_mdu_flush) begin
      state             <= ST_IDLE;
      o_mdu_out_valid   <= 1'b0;
      o_mdu_result      <= '0;
      o_mdu_tag         <= '0;
      o_mdu_div_by_zero <= 1'b0;
      o_mdu_overflow    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (i_mdu_in_valid) begin
          op_q      <= op_in;
          w32_q     <= w32_in;
          neg_q     <= sa ^ sb;
          neg_r     <= sa;
          o_mdu_tag <= i_mdu_tag;
          mcand     <= {{XLEN{1'b0}}, b_m};
          mplier    <= a_m;
          acc       <= '0;
          rem       <= '0;
          qd        <= w32_in ? a_m << (XLEN - 32) : a_m;
          dvsr      <= b_m;
          if (fast_hit) begin
            state             <= ST_DONE;
            o_mdu_out_valid   <= 1'b1;
            o_mdu_result      <= fast_res;
            o_mdu_div_by_zero <= fast_dbz;
            o_mdu_overflow    <= fast_ovf;
          end else begin
            state <= div_in ? ST_DIV : ST_MUL;
            if (div_in) cnt <= w32_in ? DIV_LAST_W : DIV_LAST_X;
            else        cnt <= w32_in ? MUL_LAST_W : MUL_LAST_X;
          end
        end
        ST_MUL: begin
          acc    <= acc + mul_pp;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier >> MUL_BITS;
          if (cnt == '0) state <= ST_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        ST_DIV: begin
          rem <= rem_nx;
          qd  <= qd_nx;
          if (cnt == '0) state <= ST_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        ST_FIX: begin
          state             <= ST_DONE;
          o_mdu_out_valid   <= 1'b1;
          o_mdu_result      <= fix_res;
          o_mdu_div_by_zero <= 1'b0;
          o_mdu_overflow    <= 1'b0;
        end
        ST_DONE: if (i_mdu_out_ready) begin
          state           <= ST_IDLE;
          o_mdu_out_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_core_mdu.sv
// tb/tb_riscv_core_mdu.sv - directed and scoreboard bench for riscv_core_mdu
module tb_riscv_core_mdu;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, in_ready, isword = 1'b0;
  logic        out_valid, out_ready = 1'b0, dbz, ovf;
  logic [2:0]  funct3 = '0;
  logic [63:0] srca = '0, srcb = '0, result;
  logic [4:0]  tag = '0, tag_o;
  int          total = 0, bad = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  riscv_core_mdu dut (
    .i_mdu_clk         (clk),
    .i_mdu_rst         (rst),
    .i_mdu_flush       (flush),
    .i_mdu_in_valid    (in_valid),
    .o_mdu_in_ready    (in_ready),
    .i_mdu_funct3      (funct3),
    .i_mdu_isword      (isword),
    .i_mdu_srcA        (srca),
    .i_mdu_srcB        (srcb),
    .i_mdu_tag         (tag),
    .o_mdu_out_valid   (out_valid),
    .i_mdu_out_ready   (out_ready),
    .o_mdu_result      (result),
    .o_mdu_tag         (tag_o),
    .o_mdu_div_by_zero (dbz),
    .o_mdu_overflow    (ovf)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mdu(input logic [2:0] f, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [127:0] sa, sb2, za, zb, p;
    logic [63:0]  r;
    sa  = {{64{a[63]}}, a};
    sb2 = {{64{b[63]}}, b};
    za  = {64'd0, a};
    zb  = {64'd0, b};
    p   = '0;
    case (f)
      3'd0:    begin p = za * zb;  r = p[63:0];   end
      3'd1:    begin p = sa * sb2; r = p[127:64]; end
      3'd2:    begin p = sa * zb;  r = p[127:64]; end
      3'd3:    begin p = za * zb;  r = p[127:64]; end
      3'd4:    r = $signed(a) / $signed(b);
      3'd5:    r = a / b;
      3'd6:    r = $signed(a) % $signed(b);
      default: r = a % b;
    endcase
    return r;
  endfunction

  task automatic run(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b,
                     input logic [4:0] t, input logic [63:0] er, input logic ed, input logic eo,
                     input int el, input int hold);
    exp_t e;
    int   n, guard;
    e.res = er; e.tag = t; e.dbz = ed; e.ovf = eo; e.lat = el;
    sb.push_back(e);
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    funct3 = f; isword = w; srca = a; srcb = b; tag = t; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sb.pop_front();
    chk("latency", 64'(n), 64'(e.lat));
    chk("result", result, e.res);
    chk("tag", 64'(tag_o), 64'(e.tag));
    chk("div_by_zero", 64'(dbz), 64'(e.dbz));
    chk("overflow", 64'(ovf), 64'(e.ovf));
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", result, e.res);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("ready_after_pop", 64'(in_ready), 64'd1);
    chk("valid_after_pop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [2:0]  f;
    logic [63:0] a, b;
    int          lat, seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_tag", 64'(tag_o), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

    run(3'b000, 1'b0, -64'sd3, 64'd7, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0, 34, 0);
    run(3'b011, 1'b0, '1, '1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 34, 0);
    run(3'b010, 1'b0, '1, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 34, 0);
    run(3'b100, 1'b1, 64'h8000_0000, '1, 5'd8, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 1, 0);
    run(3'b110, 1'b0, 64'd17, 64'd0, 5'd9, 64'd17, 1'b1, 1'b0, 1, 0);
    run(3'b001, 1'b0, 64'd0, 64'd123, 5'd10, 64'd0, 1'b0, 1'b0, 1, 0);
    run(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 18, 0);
    run(3'b101, 1'b1, 64'hFFFF_FFFF, 64'd2, 5'd12, 64'h0000_0000_7FFF_FFFF, 1'b0, 1'b0, 34, 0);
    run(3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd13, '1, 1'b0, 1'b0, 34, 0);
    run(3'b101, 1'b0, 64'd100, 64'd7, 5'd14, 64'd14, 1'b0, 1'b0, 66, 10);

    // Flush mid-divide together with a competing request.
    @(negedge clk);
    funct3 = 3'b100; isword = 1'b0; srca = 64'd5000; srcb = 64'd3; tag = 5'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; funct3 = 3'b000; srca = 64'd3; srcb = 64'd3; tag = 5'd9;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_result_clr", result, 64'd0);
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);

    run(3'b111, 1'b0, 64'd100, 64'd7, 5'd15, 64'd2, 1'b0, 1'b0, 66, 0);
    run(3'b100, 1'b0, 64'd1000, -64'sd7, 5'd16, -64'sd142, 1'b0, 1'b0, 66, 0);
`ifdef RISCV_CORE_MDU_REM_CACHE_EN
    lat = 1;
`else
    lat = 66;
`endif
    run(3'b110, 1'b0, 64'd1000, -64'sd7, 5'd17, 64'd6, 1'b0, 1'b0, lat, 0);

    for (int i = 0; i < 8; i++) begin
      f = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 60);
      if (a == '0) a = 64'd5;
      if (b == '0) b = 64'd1;
      lat = f[2] ? 66 : 34;
      run(f, 1'b0, a, b, 5'(i + 20), ref_mdu(f, a, b), 1'b0, 1'b0, lat, 0);
    end

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
